axi_lite_reg_slave: RTL and testbench

// AXI4-Lite responder: a bank of NUM_REGS word registers behind one slave port, the endpoint on a bus m1/m2 port.

---
 rtl/axi_lite_reg_slave.sv | 223 ++++++++++++++++++++++
 tb/tb_axi_lite_reg_slave.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register bank: NUM_REGS word registers, independent read/write FSMs, byte strobes, OKAY/SLVERR.
// Optional AXI_REG_WRCNT_EN adds a read-only count of OKAY writes just past the last register.
module axi_lite_reg_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 3,
    parameter int NUM_REGS   = 4,
    parameter int BASE_ADDR  = 0,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           s_axi_aclk,
    input  logic                           s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
    input  logic                           s_axi_awvalid,
    output logic                           s_axi_awready,
    input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
    input  logic                           s_axi_wvalid,
    output logic                           s_axi_wready,
    output logic [RESP_WIDTH-1:0]          s_axi_bresp,
    output logic                           s_axi_bvalid,
    input  logic                           s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
    input  logic                           s_axi_arvalid,
    output logic                           s_axi_arready,
    output logic [DATA_WIDTH-1:0]          s_axi_rdata,
    output logic [RESP_WIDTH-1:0]          s_axi_rresp,
    output logic                           s_axi_rvalid,
    input  logic                           s_axi_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [31:0] BASE       = 32'(BASE_ADDR);
    localparam logic [31:0] NREG_BYTES = 32'(4 * NUM_REGS);
    localparam logic [RESP_WIDTH-1:0] OKAY   = RESP_WIDTH'(0);
    localparam logic [RESP_WIDTH-1:0] SLVERR = RESP_WIDTH'(2);

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    wstate_t wstate_q, wstate_d;
    rstate_t rstate_q, rstate_d;
    logic aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [RESP_WIDTH-1:0] bresp_q, bresp_d, rresp_q, rresp_d;
    logic arready_q, arready_d, rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
    logic [31:0] woff, roff;
`ifdef AXI_REG_WRCNT_EN
    logic [DATA_WIDTH-1:0] wrcnt_q, wrcnt_d;
`endif

    // Offset from BASE; addresses below BASE wrap to huge values and fall out of range.
    function automatic logic [31:0] reg_off(input logic [ADDR_WIDTH-1:0] a);
        return 32'(a) - BASE;
    endfunction

    always_comb begin
        wstate_d  = wstate_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;
        woff      = reg_off(awaddr_q);
`ifdef AXI_REG_WRCNT_EN
        wrcnt_d   = wrcnt_q;
`endif
        case (wstate_q)
            W_IDLE: begin
                if (s_axi_awvalid && awready_q) begin
                    aw_done_d = 1'b1;
                    awaddr_d  = s_axi_awaddr;
                end
                if (s_axi_wvalid && wready_q) begin
                    w_done_d = 1'b1;
                    wdata_d  = s_axi_wdata;
                    wstrb_d  = s_axi_wstrb;
                end
                if (aw_done_d && w_done_d) begin
                    woff    = reg_off(awaddr_d);
                    bresp_d = SLVERR;
                    if (woff[1:0] == 2'b00 && woff < NREG_BYTES) begin
                        bresp_d = OKAY;
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (woff[31:2] == 30'(i)) begin
                                for (int k = 0; k < STRB_W; k++) begin
                                    if (wstrb_d[k]) regs_d[i][8*k +: 8] = wdata_d[8*k +: 8];
                                end
                            end
                        end
`ifdef AXI_REG_WRCNT_EN
                        wrcnt_d = wrcnt_q + DATA_WIDTH'(1);
`endif
                    end
                    bvalid_d  = 1'b1;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    wstate_d  = W_RESP;
                end else begin
                    awready_d = !aw_done_d;
                    wready_d  = !w_done_d;
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    wstate_d  = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // Reads sample regs_q, so a same-edge write is seen only by the next read.
    always_comb begin
        rstate_d  = rstate_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        roff      = reg_off(s_axi_araddr);
        case (rstate_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (s_axi_arvalid && arready_q) begin
                    rdata_d = '0;
                    rresp_d = SLVERR;
                    if (roff[1:0] == 2'b00 && roff < NREG_BYTES) begin
                        rresp_d = OKAY;
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (roff[31:2] == 30'(i)) rdata_d = regs_q[i];
                        end
                    end
`ifdef AXI_REG_WRCNT_EN
                    else if (roff == NREG_BYTES) begin
                        rresp_d = OKAY;
                        rdata_d = wrcnt_q;
                    end
`endif
                    rvalid_d  = 1'b1;
                    arready_d = 1'b0;
                    rstate_d  = R_DATA;
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    rstate_d  = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            wstate_q  <= W_IDLE;
            rstate_q  <= R_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            regs_q    <= {NUM_REGS{RESET_VALUE}};
`ifdef AXI_REG_WRCNT_EN
            wrcnt_q   <= '0;
`endif
        end else begin
            wstate_q  <= wstate_d;
            rstate_q  <= rstate_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            regs_q    <= regs_d;
`ifdef AXI_REG_WRCNT_EN
            wrcnt_q   <= wrcnt_d;
`endif
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign reg_out       = regs_q;
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Self-checking bench for axi_lite_reg_slave: directed scenarios plus randomized traffic vs. a register-array model.
module tb_axi_lite_reg_slave;
    localparam int NR   = 4;
    localparam int BASE = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  s_axi_awaddr = '0, s_axi_araddr = '0;
    logic        s_axi_awvalid = 0, s_axi_wvalid = 0, s_axi_bready = 0, s_axi_arvalid = 0, s_axi_rready = 0;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
    logic [2:0]  s_axi_bresp, s_axi_rresp;
    logic [31:0] s_axi_rdata;
    logic [NR*32-1:0] reg_out;

    axi_lite_reg_slave #(.NUM_REGS(NR), .BASE_ADDR(BASE)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .reg_out(reg_out)
    );

    int vecs = 0;
    int errs = 0;
    logic [31:0] m_regs [NR];
    logic [31:0] m_cnt;

    // Model: -1 unmapped, 0..NR-1 register, NR the write counter (when present).
    function automatic int m_idx(input logic [7:0] a);
        int off;
        off = int'(a) - BASE;
        if (off < 0 || (off % 4) != 0) return -1;
        if (off / 4 < NR) return off / 4;
`ifdef AXI_REG_WRCNT_EN
        if (off / 4 == NR) return NR;
`endif
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = 32'h0;
        m_cnt = 32'h0;
    endtask

    task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, output logic [2:0] er);
        int idx;
        idx = m_idx(a);
        if (idx >= 0 && idx < NR) begin
            for (int k = 0; k < 4; k++) if (s[k]) m_regs[idx][8*k +: 8] = d[8*k +: 8];
            m_cnt = m_cnt + 1;
            er = 3'd0;
        end else er = 3'd2;
    endtask

    task automatic model_read(input logic [7:0] a, output logic [31:0] d, output logic [2:0] er);
        int idx;
        idx = m_idx(a);
        if (idx >= 0 && idx < NR) begin d = m_regs[idx]; er = 3'd0; end
        else if (idx == NR)       begin d = m_cnt;       er = 3'd0; end
        else                      begin d = 32'h0;       er = 3'd2; end
    endtask

    function automatic logic [NR*32-1:0] exp_regout();
        logic [NR*32-1:0] r;
        for (int i = 0; i < NR; i++) r[32*i +: 32] = m_regs[i];
        return r;
    endfunction

    // Bus driver; ok clears on timeout or any handshake/stability/latency violation observed.
    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly,
                             output logic [2:0] resp, output bit ok);
        bit awd, wd;
        int c;
        awd = 0; wd = 0; c = 0; ok = 1;
        s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
        while (!(awd && wd) && c < 200) begin
            s_axi_awvalid = !awd && (c >= aw_dly);
            s_axi_wvalid  = !wd && (c >= w_dly);
            @(negedge clk);
            if ((wd && s_axi_wready) || (awd && s_axi_awready) || s_axi_bvalid) ok = 0;
            if (s_axi_awvalid && s_axi_awready) awd = 1;
            if (s_axi_wvalid && s_axi_wready) wd = 1;
            @(posedge clk); #1; c++;
        end
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        if (!(awd && wd)) begin ok = 0; resp = 3'bx; return; end
        if (!s_axi_bvalid) ok = 0;
        resp = s_axi_bresp;
        for (int i = 0; i < b_dly; i++) begin
            @(negedge clk);
            if (!s_axi_bvalid || s_axi_bresp !== resp || s_axi_awready || s_axi_wready) ok = 0;
            @(posedge clk); #1;
        end
        s_axi_bready = 1;
        @(negedge clk);
        if (!s_axi_bvalid) ok = 0;
        @(posedge clk); #1;
        s_axi_bready = 0;
        if (s_axi_bvalid) ok = 0;
    endtask

    task automatic axi_read(input logic [7:0] a, input int r_dly,
                            output logic [31:0] d, output logic [2:0] resp, output bit ok);
        bit hs;
        int c;
        hs = 0; c = 0; ok = 1;
        s_axi_araddr = a; s_axi_arvalid = 1;
        while (!hs && c < 200) begin
            @(negedge clk);
            if (s_axi_arready) hs = 1;
            if (s_axi_rvalid) ok = 0;
            @(posedge clk); #1; c++;
        end
        s_axi_arvalid = 0;
        if (!hs) begin ok = 0; d = 32'bx; resp = 3'bx; return; end
        if (!s_axi_rvalid) ok = 0;
        d = s_axi_rdata; resp = s_axi_rresp;
        for (int i = 0; i < r_dly; i++) begin
            @(negedge clk);
            if (!s_axi_rvalid || s_axi_rdata !== d || s_axi_rresp !== resp || s_axi_arready) ok = 0;
            @(posedge clk); #1;
        end
        s_axi_rready = 1;
        @(negedge clk);
        @(posedge clk); #1;
        s_axi_rready = 0;
        if (s_axi_rvalid) ok = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        model_reset();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        vecs++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, s_axi_bresp, s_axi_rresp, s_axi_rdata} !== '0) begin
            errs++; $display("FAIL reset_outputs: got aw/w/ar rdy %b%b%b bv %b rv %b rdata %h, need all 0",
                             s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, s_axi_rdata);
        end
        model_reset();
        vecs++;
        if (reg_out !== exp_regout()) begin errs++; $display("FAIL reset_regs: got %h need %h", reg_out, exp_regout()); end
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        vecs++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
            errs++; $display("FAIL reset_release_ready: got %b need 111", {s_axi_awready, s_axi_wready, s_axi_arready});
        end
    endtask

    task automatic test_basic();
        logic [2:0] r, er; logic [31:0] d, ed; bit ok;
        axi_write(8'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, r, ok);
        model_write(8'h04, 32'hDEADBEEF, 4'hF, er);
        vecs++; if (!ok || r !== 3'd0) begin errs++; $display("FAIL basic_bresp: got %0d ok=%0d need 0 ok=1", r, ok); end
        vecs++; if (reg_out[63:32] !== 32'hDEADBEEF) begin errs++; $display("FAIL basic_reg_out: got %h need deadbeef", reg_out[63:32]); end
        axi_read(8'h04, 0, d, r, ok);
        model_read(8'h04, ed, er);
        vecs++; if (!ok || d !== 32'hDEADBEEF || r !== er) begin errs++; $display("FAIL basic_read: got %h/%0d ok=%0d need %h/%0d", d, r, ok, ed, er); end
    endtask

    task automatic test_w_first();
        logic [2:0] r, er; bit ok;
        axi_write(8'h00, 32'h12345678, 4'hF, 3, 0, 0, r, ok);
        model_write(8'h00, 32'h12345678, 4'hF, er);
        vecs++; if (!ok || r !== er) begin errs++; $display("FAIL w_first_resp: got %0d ok=%0d need %0d ok=1", r, ok, er); end
        vecs++; if (reg_out[31:0] !== 32'h12345678) begin errs++; $display("FAIL w_first_reg0: got %h need 12345678", reg_out[31:0]); end
        axi_write(8'h0C, 32'hA5A5_0F0F, 4'hF, 0, 4, 0, r, ok);
        model_write(8'h0C, 32'hA5A5_0F0F, 4'hF, er);
        vecs++; if (!ok || reg_out !== exp_regout()) begin errs++; $display("FAIL aw_first: got %h ok=%0d need %h", reg_out, ok, exp_regout()); end
    endtask

    task automatic test_strobe();
        logic [2:0] r, er; bit ok;
        axi_write(8'h00, 32'hFFFFFFFF, 4'hF, 0, 0, 0, r, ok);
        model_write(8'h00, 32'hFFFFFFFF, 4'hF, er);
        axi_write(8'h00, 32'h0, 4'h5, 0, 0, 0, r, ok);
        model_write(8'h00, 32'h0, 4'h5, er);
        vecs++; if (!ok || r !== 3'd0 || reg_out[31:0] !== 32'hFF00FF00) begin
            errs++; $display("FAIL strobe_0x5: got %h resp %0d ok=%0d need ff00ff00", reg_out[31:0], r, ok);
        end
        axi_write(8'h00, 32'h0, 4'h0, 0, 0, 0, r, ok);
        model_write(8'h00, 32'h0, 4'h0, er);
        vecs++; if (!ok || r !== 3'd0 || reg_out !== exp_regout()) begin
            errs++; $display("FAIL strobe_none: got %h resp %0d need %h", reg_out, r, exp_regout());
        end
    endtask

    task automatic test_decode();
        logic [2:0] r, er; logic [31:0] d, ed; bit ok;
        logic [7:0] bad [3];
        bad[0] = 8'h40; bad[1] = 8'h02; bad[2] = 8'h14;
        for (int i = 0; i < 3; i++) begin
            axi_read(bad[i], 0, d, r, ok);
            model_read(bad[i], ed, er);
            vecs++; if (!ok || r !== 3'd2 || d !== 32'h0 || r !== er) begin
                errs++; $display("FAIL decode_read_%h: got %h/%0d ok=%0d need 0/2", bad[i], d, r, ok);
            end
        end
        axi_write(8'h40, $urandom, 4'hF, 0, 0, 0, r, ok);
        model_write(8'h40, 32'h0, 4'hF, er);
        vecs++; if (!ok || r !== 3'd2 || reg_out !== exp_regout()) begin
            errs++; $display("FAIL decode_write_40: got resp %0d regs %h need 2 regs %h", r, reg_out, exp_regout());
        end
    endtask

    task automatic test_stall();
        logic [2:0] r, er; logic [31:0] d, ed, v; bit ok;
        v = $urandom;
        axi_write(8'h08, v, 4'hF, 0, 0, 10, r, ok);
        model_write(8'h08, v, 4'hF, er);
        vecs++; if (!ok || r !== er) begin errs++; $display("FAIL stall_bready: resp %0d ok=%0d need %0d ok=1", r, ok, er); end
        axi_read(8'h08, 10, d, r, ok);
        model_read(8'h08, ed, er);
        vecs++; if (!ok || d !== ed || r !== er) begin errs++; $display("FAIL stall_rready: got %h/%0d ok=%0d need %h/%0d", d, r, ok, ed, er); end
    endtask

    task automatic test_async_reset();
        logic [2:0] r, er; logic [31:0] d, ed; bit ok;
        s_axi_awaddr = 8'h08; s_axi_wdata = 32'hCAFEF00D; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1; s_axi_wvalid = 1;
        @(negedge clk);
        @(posedge clk); #1;
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        vecs++; if (s_axi_bvalid !== 1'b1) begin errs++; $display("FAIL arst_pending: bvalid %b need 1", s_axi_bvalid); end
        #2 rst_n = 0;
        #1;
        model_reset();
        vecs++; if (s_axi_bvalid !== 1'b0 || reg_out !== exp_regout() || s_axi_awready !== 1'b0) begin
            errs++; $display("FAIL arst_drop: bvalid %b awready %b regs %h need 0 0 %h", s_axi_bvalid, s_axi_awready, reg_out, exp_regout());
        end
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        axi_write(8'h04, 32'h0BADCAFE, 4'hF, 0, 0, 0, r, ok);
        model_write(8'h04, 32'h0BADCAFE, 4'hF, er);
        axi_read(8'h04, 0, d, r, ok);
        model_read(8'h04, ed, er);
        vecs++; if (!ok || d !== ed || r !== er || reg_out !== exp_regout()) begin
            errs++; $display("FAIL arst_recover: got %h/%0d need %h/%0d", d, r, ed, er);
        end
    endtask

    task automatic test_wrcnt();
        logic [2:0] r, er; logic [31:0] d; bit ok;
        logic [31:0] need_d; logic [2:0] need_r;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            axi_write(8'(4 * i), $urandom, 4'hF, 0, 0, 0, r, ok);
            model_write(8'(4 * i), 32'h0, 4'h0, er);
        end
        axi_write(8'h40, $urandom, 4'hF, 0, 0, 0, r, ok);
        model_write(8'h40, 32'h0, 4'hF, er);
`ifdef AXI_REG_WRCNT_EN
        need_d = 32'd3; need_r = 3'd0;
`else
        need_d = 32'd0; need_r = 3'd2;
`endif
        axi_read(8'h10, 0, d, r, ok);
        vecs++; if (!ok || d !== need_d || r !== need_r) begin errs++; $display("FAIL wrcnt_read: got %h/%0d need %h/%0d", d, r, need_d, need_r); end
        axi_write(8'h10, 32'hFFFFFFFF, 4'hF, 0, 0, 0, r, ok);
        model_write(8'h10, 32'hFFFFFFFF, 4'hF, er);
        vecs++; if (!ok || r !== 3'd2) begin errs++; $display("FAIL wrcnt_write: got resp %0d need 2", r); end
        axi_read(8'h10, 0, d, r, ok);
        vecs++; if (!ok || d !== need_d || r !== need_r) begin errs++; $display("FAIL wrcnt_unchanged: got %h/%0d need %h/%0d", d, r, need_d, need_r); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] wr, rr, er, err_r; logic [31:0] d, ed, v; bit okw, okr;
        v = $urandom;
        model_read(8'h00, ed, err_r);
        fork
            axi_write(8'h0C, v, 4'hF, 0, 0, 0, wr, okw);
            axi_read(8'h00, 0, d, rr, okr);
        join
        model_write(8'h0C, v, 4'hF, er);
        vecs++; if (!okw || !okr || wr !== er || d !== ed || rr !== err_r || reg_out !== exp_regout()) begin
            errs++; $display("FAIL concurrent: w %0d r %h/%0d need w %0d r %h/%0d", wr, d, rr, er, ed, err_r);
        end
    endtask

    task automatic test_random();
        logic [2:0] r, er; logic [31:0] d, ed, v; logic [3:0] s; logic [7:0] a; bit ok;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 7))
                0, 1, 2, 3: a = 8'(BASE + 4 * $urandom_range(0, NR - 1));
                4:          a = 8'(BASE + 4 * NR);
                5:          a = 8'(BASE + 4 * $urandom_range(0, NR - 1) + $urandom_range(1, 3));
                6:          a = 8'($urandom_range(BASE + 4 * NR + 4, 255));
                default:    a = 8'($urandom);
            endcase
            if ($urandom_range(0, 1) == 0) begin
                v = $urandom; s = 4'($urandom_range(0, 15));
                axi_write(a, v, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), r, ok);
                model_write(a, v, s, er);
                vecs++; if (!ok || r !== er || reg_out !== exp_regout()) begin
                    errs++; $display("FAIL rand_write a=%h: resp %0d ok=%0d regs %h need %0d %h", a, r, ok, reg_out, er, exp_regout());
                end
            end else begin
                axi_read(a, $urandom_range(0, 3), d, r, ok);
                model_read(a, ed, er);
                vecs++; if (!ok || d !== ed || r !== er) begin
                    errs++; $display("FAIL rand_read a=%h: got %h/%0d ok=%0d need %h/%0d", a, d, r, ok, ed, er);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_w_first();
        test_strobe();
        test_decode();
        test_stall();
        test_async_reset();
        test_back_to_back();
        test_random();
        test_wrcnt();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
